// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered, handshaked ALU control decoder.
// Decodes ALUOp/funct into a 4-bit ALU control code, flags unrecognised
// R-type functs and holds off upstream while a multi-cycle MUL (and, with
// ALU_CTRL_DIV_EN defined, DIV/REM) is in progress.
//
// Optional feature macro: ALU_CTRL_DIV_EN
//   defined   -> funct 0000001_10x decodes to DIV, 0000001_11x to REM,
//                both multi-cycle using DIV_CYCLES.
//   undefined -> those functs are illegal (ADD, illegal_o=1, single-cycle).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no result pending, ready for a new request
// MULTI | multi-cycle op running, counter counts down to 0
// OUT   | result presented to the ALU, held until ready_i
module alu_ctrl_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic [9:0] funct_i,
    input  logic [1:0] ALUOp_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [3:0] ALUCtrl_o,
    output logic       busy_o,
    output logic       illegal_o
);

    localparam logic [3:0] C_ADD  = 4'h1;
    localparam logic [3:0] C_SUB  = 4'h2;
    localparam logic [3:0] C_AND  = 4'h3;
    localparam logic [3:0] C_OR   = 4'h4;
    localparam logic [3:0] C_XOR  = 4'h5;
    localparam logic [3:0] C_MUL  = 4'h6;
    localparam logic [3:0] C_SLL  = 4'h7;
    localparam logic [3:0] C_SRL  = 4'h8;
    localparam logic [3:0] C_SRA  = 4'h9;
    localparam logic [3:0] C_SLT  = 4'hA;
    localparam logic [3:0] C_SLTU = 4'hB;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [3:0] C_DIV  = 4'hC;
    localparam logic [3:0] C_REM  = 4'hD;
`endif

    // Counter loads are one less than the cycle count: MULTI exits on the
    // edge after the counter reads zero, so it lasts exactly N cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       dec_code;
    logic             dec_illegal;
    logic             dec_multi;
    logic             dec_div;
    logic             accept;

    // Combinational decode of the incoming request.
    always_comb begin
        dec_code    = C_ADD;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        dec_div     = 1'b0;
        case (ALUOp_i)
            2'b01: dec_code = C_SUB;
            2'b10: begin
                case (funct_i)
                    10'b0000000_000: dec_code = C_ADD;
                    10'b0100000_000: dec_code = C_SUB;
                    10'b0000000_001: dec_code = C_SLL;
                    10'b0000000_010: dec_code = C_SLT;
                    10'b0000000_011: dec_code = C_SLTU;
                    10'b0000000_100: dec_code = C_XOR;
                    10'b0000000_101: dec_code = C_SRL;
                    10'b0100000_101: dec_code = C_SRA;
                    10'b0000000_110: dec_code = C_OR;
                    10'b0000000_111: dec_code = C_AND;
                    10'b0000001_000: begin
                        dec_code  = C_MUL;
                        dec_multi = 1'b1;
                    end
`ifdef ALU_CTRL_DIV_EN
                    10'b0000001_100, 10'b0000001_101: begin
                        dec_code  = C_DIV;
                        dec_multi = 1'b1;
                        dec_div   = 1'b1;
                    end
                    10'b0000001_110, 10'b0000001_111: begin
                        dec_code  = C_REM;
                        dec_multi = 1'b1;
                        dec_div   = 1'b1;
                    end
`endif
                    default: begin
                        dec_code    = C_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_code = C_ADD;
        endcase
    end

    // Handshake: a pending result frees the slot in the same cycle it is consumed.
    always_comb begin
        ready_o = (state_q == IDLE) || ((state_q == OUT) && ready_i);
        accept  = valid_i && ready_o;
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, OUT: begin
                if (accept) begin
                    ctrl_d = dec_code;
                    if (dec_multi) begin
                        state_d   = MULTI;
                        illegal_d = 1'b0;
                        cnt_d     = dec_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        state_d   = OUT;
                        illegal_d = dec_illegal;
                    end
                end else if (state_q == OUT && ready_i) begin
                    state_d = IDLE;
                end
            end
            MULTI: begin
                if (cnt_q == '0) begin
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, result and counter registers; reset aborts any in-flight op.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ctrl_q    <= C_ADD;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        valid_o   = (state_q == OUT);
        busy_o    = (state_q == MULTI);
        ALUCtrl_o = ctrl_q;
        illegal_o = illegal_q && (state_q == OUT);
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with default parameters (MUL_CYCLES=4,
// DIV_CYCLES=8). DIV expectations follow ALU_CTRL_DIV_EN.
module tb_alu_ctrl_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [9:0] funct_i;
    logic [1:0] ALUOp_i;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] ALUCtrl_o;
    logic       busy_o;
    logic       illegal_o;

    int n_chk  = 0;
    int n_fail = 0;

    alu_ctrl_seq dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ALUCtrl_o (ALUCtrl_o),
        .busy_o    (busy_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        funct_i = '0;
        ALUOp_i = 2'b00;
        ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // reset state
        chk("rst_valid", valid_o, 0);
        chk("rst_ctrl", ALUCtrl_o, 4'h1);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_illegal", illegal_o, 0);

        // back-to-back SUB then AND
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = 10'b0100000_000;
        tick();
        chk("b2b_sub_ctrl", ALUCtrl_o, 4'h2);
        chk("b2b_sub_valid", valid_o, 1);
        chk("b2b_sub_ready", ready_o, 1);
        funct_i = 10'b0000000_111;
        tick();
        chk("b2b_and_ctrl", ALUCtrl_o, 4'h3);
        chk("b2b_and_valid", valid_o, 1);
        valid_i = 1'b0;
        tick();
        chk("b2b_idle_valid", valid_o, 0);

        // MUL: busy 4 cycles, then result
        valid_i = 1'b1;
        funct_i = 10'b0000001_000;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mul_busy", busy_o, 1);
            chk("mul_ready", ready_o, 0);
            chk("mul_valid", valid_o, 0);
            tick();
        end
        chk("mul_done_valid", valid_o, 1);
        chk("mul_done_ctrl", ALUCtrl_o, 4'h6);
        chk("mul_done_busy", busy_o, 0);
        tick();
        chk("mul_idle_valid", valid_o, 0);

        // backpressure: XOR held while ready_i=0, pending OR waits
        valid_i = 1'b1;
        funct_i = 10'b0000000_100;
        ready_i = 1'b0;
        tick();
        funct_i = 10'b0000000_110;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", valid_o, 1);
            chk("bp_ctrl", ALUCtrl_o, 4'h5);
            chk("bp_ready", ready_o, 0);
            tick();
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release_ready", ready_o, 1);
        chk("bp_release_ctrl", ALUCtrl_o, 4'h5);
        tick();
        chk("bp_or_ctrl", ALUCtrl_o, 4'h4);
        chk("bp_or_valid", valid_o, 1);
        valid_i = 1'b0;
        tick();
        chk("bp_idle_valid", valid_o, 0);

        // illegal funct, then branch
        valid_i = 1'b1;
        funct_i = 10'b1111111_000;
        tick();
        chk("ill_ctrl", ALUCtrl_o, 4'h1);
        chk("ill_flag", illegal_o, 1);
        chk("ill_valid", valid_o, 1);
        ALUOp_i = 2'b01;
        tick();
        chk("br_ctrl", ALUCtrl_o, 4'h2);
        chk("br_illegal", illegal_o, 0);

        // more decode points
        ALUOp_i = 2'b10;
        funct_i = 10'b0100000_101;
        tick();
        chk("sra_ctrl", ALUCtrl_o, 4'h9);
        funct_i = 10'b0000000_011;
        tick();
        chk("sltu_ctrl", ALUCtrl_o, 4'hB);
        funct_i = 10'b0000000_001;
        tick();
        chk("sll_ctrl", ALUCtrl_o, 4'h7);
        ALUOp_i = 2'b11;
        funct_i = 10'b1111111_111;
        tick();
        chk("addi_ctrl", ALUCtrl_o, 4'h1);
        chk("addi_illegal", illegal_o, 0);
        ALUOp_i = 2'b00;
        funct_i = 10'b0100000_000;
        tick();
        chk("add_ctrl", ALUCtrl_o, 4'h1);
        valid_i = 1'b0;
        tick();

        // REM / DIV path
        valid_i = 1'b1;
        ALUOp_i = 2'b10;
        funct_i = 10'b0000001_110;
        tick();
        valid_i = 1'b0;
`ifdef ALU_CTRL_DIV_EN
        for (int i = 0; i < 8; i++) begin
            chk("div_busy", busy_o, 1);
            chk("div_valid", valid_o, 0);
            tick();
        end
        chk("rem_ctrl", ALUCtrl_o, 4'hD);
        chk("rem_valid", valid_o, 1);
        chk("rem_illegal", illegal_o, 0);
`else
        chk("rem_off_ctrl", ALUCtrl_o, 4'h1);
        chk("rem_off_illegal", illegal_o, 1);
        chk("rem_off_valid", valid_o, 1);
        chk("rem_off_busy", busy_o, 0);
`endif
        tick();

        // async reset mid multi-cycle op
        valid_i = 1'b1;
        funct_i = 10'b0000001_000;
        tick();
        valid_i = 1'b0;
        tick();
        chk("abort_pre_busy", busy_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_ready", ready_o, 1);
        chk("abort_ctrl", ALUCtrl_o, 4'h1);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_valid", valid_o, 0);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
